// File: rtl/bip_pkg.sv
// Shared encodings for the accumulator processor: widths, opcodes, source
// selects, FSM states and the decoded control bundle.
package bip_pkg;

  localparam int unsigned N_BUS     = 16;
  localparam int unsigned N_OPCODE  = 5;
  localparam int unsigned N_OPERAND = 11;
  localparam int unsigned N_ADDR    = 11;
  localparam int unsigned N_CNT     = 16;

  localparam logic [N_OPCODE-1:0] OP_HLT  = 5'b00000;
  localparam logic [N_OPCODE-1:0] OP_STO  = 5'b00001;
  localparam logic [N_OPCODE-1:0] OP_LD   = 5'b00010;
  localparam logic [N_OPCODE-1:0] OP_LDI  = 5'b00011;
  localparam logic [N_OPCODE-1:0] OP_ADD  = 5'b00100;
  localparam logic [N_OPCODE-1:0] OP_ADDI = 5'b00101;
  localparam logic [N_OPCODE-1:0] OP_SUB  = 5'b00110;
  localparam logic [N_OPCODE-1:0] OP_SUBI = 5'b00111;

  localparam logic [1:0] SEL_A_RAM = 2'b00;
  localparam logic [1:0] SEL_A_IMM = 2'b01;
  localparam logic [1:0] SEL_A_ALU = 2'b10;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_HALT = 2'b10;

  typedef struct packed {
    logic [1:0] sel_a;
    logic       sel_b;
    logic       wr_acc;
    logic       op;
    logic       wr_ram;
    logic       rd_ram;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/bip_if.sv
// Instruction fetch and datapath control bus between bip_control (master)
// and the program memory / datapath (slave).
interface bip_if;
  import bip_pkg::*;

  logic                 i_start;
  logic [N_BUS-1:0]     i_instr;
  logic [N_ADDR-1:0]    o_pc_addr;
  logic [N_OPERAND-1:0] o_operand;
  logic [1:0]           o_sel_a;
  logic                 o_sel_b;
  logic                 o_wr_acc;
  logic                 o_op;
  logic                 o_wr_ram;
  logic                 o_rd_ram;
  logic                 o_halt;
  logic [N_CNT-1:0]     o_cycle_cnt;

  modport master (
    input  i_start, i_instr,
    output o_pc_addr, o_operand, o_sel_a, o_sel_b, o_wr_acc, o_op,
           o_wr_ram, o_rd_ram, o_halt, o_cycle_cnt
  );

  modport slave (
    output i_start, i_instr,
    input  o_pc_addr, o_operand, o_sel_a, o_sel_b, o_wr_acc, o_op,
           o_wr_ram, o_rd_ram, o_halt, o_cycle_cnt
  );

endinterface

// File: rtl/bip_decoder.sv
// Combinational opcode decoder: opcode in, datapath control bundle out.
module bip_decoder
  import bip_pkg::*;
(
  input  logic [N_OPCODE-1:0] opcode,
  output ctrl_t               ctrl_c,
  output logic                is_hlt_c
);

  always_comb begin
    ctrl_c   = CTRL_NONE;
    is_hlt_c = 1'b0;
    case (opcode)
      OP_HLT: is_hlt_c = 1'b1;
      OP_STO: ctrl_c.wr_ram = 1'b1;
      OP_LD: begin
        ctrl_c.rd_ram = 1'b1;
        ctrl_c.sel_a  = SEL_A_RAM;
        ctrl_c.wr_acc = 1'b1;
      end
      OP_LDI: begin
        ctrl_c.sel_a  = SEL_A_IMM;
        ctrl_c.wr_acc = 1'b1;
      end
      OP_ADD, OP_SUB: begin
        ctrl_c.rd_ram = 1'b1;
        ctrl_c.sel_b  = 1'b0;
        ctrl_c.sel_a  = SEL_A_ALU;
        ctrl_c.op     = (opcode == OP_SUB);
        ctrl_c.wr_acc = 1'b1;
      end
      OP_ADDI, OP_SUBI: begin
        ctrl_c.sel_b  = 1'b1;
        ctrl_c.sel_a  = SEL_A_ALU;
        ctrl_c.op     = (opcode == OP_SUBI);
        ctrl_c.wr_acc = 1'b1;
      end
      default: ;  // undefined opcodes execute as NOP
    endcase
  end

endmodule

// File: rtl/bip_control.sv
// Control unit of the accumulator processor: run/halt FSM, program counter,
// saturating run-cycle counter and state-gated instruction decode.
module bip_control
  import bip_pkg::*;
(
  input  logic  i_clock,
  input  logic  i_reset,
  bip_if.master bus
);

  logic [1:0]        state_q, state_d;
  logic [N_ADDR-1:0] pc_q, pc_d;
  logic [N_CNT-1:0]  cnt_q, cnt_d;
  ctrl_t             dec_ctrl, ctrl;
  logic              dec_hlt;

  bip_decoder u_decoder (
    .opcode   (bus.i_instr[N_BUS-1 -: N_OPCODE]),
    .ctrl_c   (dec_ctrl),
    .is_hlt_c (dec_hlt)
  );

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, PC and counter; decode is only exposed while running.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    ctrl    = CTRL_NONE;
    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (bus.i_start) begin
          state_d = ST_RUN;
          pc_d    = '0;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        ctrl = dec_ctrl;
        if (cnt_q != {N_CNT{1'b1}}) cnt_d = cnt_q + N_CNT'(1);
        // HLT parks the PC on its own address; everything else advances and wraps
        if (dec_hlt) state_d = ST_HALT;
        else         pc_d    = pc_q + N_ADDR'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.o_pc_addr   = pc_q;
  assign bus.o_operand   = bus.i_instr[N_OPERAND-1:0];
  assign bus.o_sel_a     = ctrl.sel_a;
  assign bus.o_sel_b     = ctrl.sel_b;
  assign bus.o_wr_acc    = ctrl.wr_acc;
  assign bus.o_op        = ctrl.op;
  assign bus.o_wr_ram    = ctrl.wr_ram;
  assign bus.o_rd_ram    = ctrl.rd_ram;
  assign bus.o_halt      = (state_q == ST_HALT);
  assign bus.o_cycle_cnt = cnt_q;

endmodule
